// File: rtl/awgn_clt_gauss_if.sv
// Handshake bundle between the URNG source, the CLT Gaussian former and the noise datapath.
// The master side drives the uniform stream and downstream ready; the slave side is the former itself.
interface awgn_clt_gauss_if #(
   parameter int unsigned OUT_W = 18
);
   logic [31:0]      urng_in;
   logic             urng_valid;
   logic             urng_ready;
   logic [OUT_W-1:0] gauss_out;
   logic             gauss_valid;
   logic             gauss_ready;
   logic [31:0]      gauss_count;

   modport master (
      output urng_in, urng_valid, gauss_ready,
      input  urng_ready, gauss_out, gauss_valid, gauss_count
   );

   modport slave (
      input  urng_in, urng_valid, gauss_ready,
      output urng_ready, gauss_out, gauss_valid, gauss_count
   );
endinterface

// File: rtl/awgn_clt_gauss.sv
// Central-limit Gaussian former: sums N_SUM uniform MSB slices and recentres the sum to a
// signed zero-mean sample held in a valid/ready output register.
module awgn_clt_gauss #(
   parameter int unsigned N_SUM = 4,
   parameter int unsigned IN_W  = 16
) (
   input logic             clk,
   input logic             rstn,
   awgn_clt_gauss_if.slave bus
);
   localparam int unsigned      CNT_W    = $clog2(N_SUM);
   localparam int unsigned      OUT_W    = IN_W + CNT_W;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_SUM - 1);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [OUT_W-1:0] r_acc;
   logic [OUT_W-1:0] w_acc_nxt;
   logic [OUT_W-1:0] r_gauss_out;
   logic [OUT_W-1:0] w_gauss_out_nxt;
   logic             r_gauss_valid;
   logic             w_gauss_valid_nxt;
   logic [31:0]      r_gauss_count;
   logic [31:0]      w_gauss_count_nxt;

   logic [OUT_W-1:0] w_u;
   logic [OUT_W-1:0] w_sum;
   logic             w_last;
   logic             w_urng_ready;
   logic             w_accept;
   logic             w_xfer;
   logic             w_unused_urng;

   assign w_u           = OUT_W'(bus.urng_in[31 -: IN_W]);
   assign w_sum         = r_acc + w_u;
   assign w_last        = (r_cnt == CNT_LAST);
   assign w_unused_urng = ^bus.urng_in;

   // Only the group-closing sample can stall, and only when the held result is not leaving.
   assign w_urng_ready  = !(w_last && r_gauss_valid && !bus.gauss_ready);
   assign w_accept      = bus.urng_valid && w_urng_ready;
   assign w_xfer        = r_gauss_valid && bus.gauss_ready;

   always_comb begin
      w_cnt_nxt         = r_cnt;
      w_acc_nxt         = r_acc;
      w_gauss_out_nxt   = r_gauss_out;
      w_gauss_valid_nxt = r_gauss_valid;
      w_gauss_count_nxt = r_gauss_count;

      if (w_xfer) begin
         w_gauss_valid_nxt = 1'b0;
         w_gauss_count_nxt = r_gauss_count + 32'd1;
      end

      if (w_accept) begin
         if (w_last) begin
            // Subtracting N_SUM*2^(IN_W-1) = 2^(OUT_W-1) is an MSB flip of the unsigned sum.
            w_gauss_out_nxt   = {~w_sum[OUT_W-1], w_sum[OUT_W-2:0]};
            w_gauss_valid_nxt = 1'b1;
            w_acc_nxt         = '0;
            w_cnt_nxt         = '0;
         end else begin
            w_acc_nxt = w_sum;
            w_cnt_nxt = r_cnt + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_cnt         <= '0;
         r_acc         <= '0;
         r_gauss_out   <= '0;
         r_gauss_valid <= 1'b0;
         r_gauss_count <= '0;
      end else begin
         r_cnt         <= w_cnt_nxt;
         r_acc         <= w_acc_nxt;
         r_gauss_out   <= w_gauss_out_nxt;
         r_gauss_valid <= w_gauss_valid_nxt;
         r_gauss_count <= w_gauss_count_nxt;
      end
   end

   assign bus.urng_ready  = w_urng_ready;
   assign bus.gauss_out   = r_gauss_out;
   assign bus.gauss_valid = r_gauss_valid;
   assign bus.gauss_count = r_gauss_count;

endmodule

// File: tb/tb_awgn_clt_gauss.sv
// Bench for awgn_clt_gauss: directed cases plus an LFSR stream, checked against a
// queue of expected samples built from accepted uniform words.
module tb_awgn_clt_gauss;
   localparam int unsigned N_SUM = 4;
   localparam int unsigned IN_W  = 16;
   localparam int unsigned OUT_W = 18;

   logic clk  = 1'b0;
   logic rstn = 1'b0;

   awgn_clt_gauss_if #(.OUT_W(OUT_W)) bus();

   awgn_clt_gauss #(.N_SUM(N_SUM), .IN_W(IN_W)) u_dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int n_chk   = 0;
   int n_err   = 0;
   int n_deliv = 0;
   int m_sum   = 0;
   int m_n     = 0;
   logic             rnd_en    = 1'b0;
   logic             hold_prev = 1'b0;
   logic [OUT_W-1:0] hold_out  = '0;
   logic [OUT_W-1:0] exp_q[$];
   logic [31:0]      lfsr      = 32'hACE1_2468;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Scoreboard: build expected samples from accepts, compare on every transfer.
   initial begin
      forever begin
         @(posedge clk or negedge rstn);
         if (!rstn) begin
            m_sum     = 0;
            m_n       = 0;
            n_deliv   = 0;
            hold_prev = 1'b0;
            exp_q.delete();
         end else begin
            if (hold_prev) begin
               chk("hold_out", 32'(bus.gauss_out), 32'(hold_out));
               chk("hold_valid", 32'(bus.gauss_valid), 32'd1);
            end
            if (bus.gauss_valid && bus.gauss_ready) begin
               chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
               if (exp_q.size() != 0) chk("sb_data", 32'(bus.gauss_out), 32'(exp_q.pop_front()));
               n_deliv++;
            end
            if (bus.urng_valid && bus.urng_ready) begin
               m_sum += int'(bus.urng_in[31:16]);
               m_n++;
               if (m_n == N_SUM) begin
                  exp_q.push_back(OUT_W'(m_sum - int'(N_SUM) * (1 << (IN_W - 1))));
                  m_sum = 0;
                  m_n   = 0;
               end
            end
            hold_prev = bus.gauss_valid && !bus.gauss_ready;
            hold_out  = bus.gauss_out;
         end
      end
   end

   // Called at a negedge; returns at the negedge after the word is accepted, valid left high.
   task automatic send(input logic [31:0] w);
      logic acc;
      acc = 1'b0;
      bus.urng_valid = 1'b1;
      bus.urng_in    = w;
      for (int k = 0; k < 100 && !acc; k++) begin
         if (rnd_en) bus.gauss_ready = 1'($urandom_range(0, 1));
         @(posedge clk);
         acc = bus.urng_ready;
         @(negedge clk);
      end
      chk("send_timeout", 32'(acc), 32'd1);
   endtask

   task automatic next_lfsr();
      lfsr = {lfsr[30:0], 1'b0} ^ (lfsr[31] ? 32'h0040_0007 : 32'h0);
   endtask

   int n_seen;
   logic [6:0] gap_pat;

   initial begin
      bus.urng_valid  = 1'b0;
      bus.urng_in     = '0;
      bus.gauss_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_valid", 32'(bus.gauss_valid), 32'd0);
      chk("rst_out", 32'(bus.gauss_out), 32'd0);
      chk("rst_count", bus.gauss_count, 32'd0);
      chk("rst_ready", 32'(bus.urng_ready), 32'd1);
      rstn = 1'b1;
      @(negedge clk);

      // Mid-scale
      repeat (4) send(32'h8000_0000);
      bus.urng_valid = 1'b0;
      chk("mid_valid", 32'(bus.gauss_valid), 32'd1);
      chk("mid_out", 32'(bus.gauss_out), 32'h00000);
      @(negedge clk);
      chk("mid_valid_drop", 32'(bus.gauss_valid), 32'd0);
      chk("mid_count", bus.gauss_count, 32'd1);

      // Extremes
      repeat (4) send(32'hFFFF_1234);
      chk("ext_hi", 32'(bus.gauss_out), 32'h1FFFC);
      repeat (4) send(32'h0000_FFFF);
      bus.urng_valid = 1'b0;
      chk("ext_lo", 32'(bus.gauss_out), 32'h20000);
      @(negedge clk);
      chk("ext_count", bus.gauss_count, 32'd3);

      // Back-pressure
      bus.gauss_ready = 1'b0;
      repeat (4) send(32'hC000_0000);
      repeat (3) send(32'h8001_0000);
      bus.urng_valid = 1'b1;
      bus.urng_in    = 32'h8001_0000;
      #1;
      chk("bp_stall", 32'(bus.urng_ready), 32'd0);
      repeat (2) begin
         @(negedge clk);
         chk("bp_hold_out", 32'(bus.gauss_out), 32'h10000);
         chk("bp_hold_valid", 32'(bus.gauss_valid), 32'd1);
         chk("bp_hold_stall", 32'(bus.urng_ready), 32'd0);
      end
      bus.gauss_ready = 1'b1;
      #1;
      chk("bp_release", 32'(bus.urng_ready), 32'd1);
      @(negedge clk);
      bus.urng_valid = 1'b0;
      chk("bp_second_out", 32'(bus.gauss_out), 32'h00004);
      chk("bp_second_valid", 32'(bus.gauss_valid), 32'd1);
      chk("bp_count", bus.gauss_count, 32'd4);
      @(negedge clk);
      chk("bp_count_after", bus.gauss_count, 32'd5);

      // Gapped input
      gap_pat = 7'b1011001;
      n_seen  = 0;
      bus.urng_in = 32'h8000_0000;
      for (int i = 0; i < 7; i++) begin
         if (bus.gauss_valid) n_seen++;
         bus.urng_valid = gap_pat[6 - i];
         @(negedge clk);
      end
      bus.urng_valid = 1'b0;
      chk("gap_early", 32'(n_seen), 32'd0);
      chk("gap_valid", 32'(bus.gauss_valid), 32'd1);
      chk("gap_out", 32'(bus.gauss_out), 32'h00000);
      @(negedge clk);
      chk("gap_count", bus.gauss_count, 32'd6);

      // Reset mid-group
      repeat (2) send(32'hFFFF_0000);
      bus.urng_valid = 1'b0;
      @(posedge clk);
      #3 rstn = 1'b0;
      #1;
      chk("arst_valid", 32'(bus.gauss_valid), 32'd0);
      chk("arst_out", 32'(bus.gauss_out), 32'd0);
      chk("arst_count", bus.gauss_count, 32'd0);
      chk("arst_ready", 32'(bus.urng_ready), 32'd1);
      #1 rstn = 1'b1;
      @(negedge clk);
      repeat (2) send(32'h8000_0000);
      chk("arst_no_early", 32'(bus.gauss_valid), 32'd0);
      repeat (2) send(32'h8000_0000);
      bus.urng_valid = 1'b0;
      chk("arst_valid_new", 32'(bus.gauss_valid), 32'd1);
      chk("arst_out_new", 32'(bus.gauss_out), 32'd0);
      @(negedge clk);

      // Sustained LFSR stream with random downstream ready
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      chk("sus_count0", bus.gauss_count, 32'd0);
      rnd_en = 1'b1;
      for (int i = 0; i < 4096; i++) begin
         send(lfsr);
         next_lfsr();
      end
      bus.urng_valid = 1'b0;
      rnd_en = 1'b0;
      @(negedge clk);
      bus.gauss_ready = 1'b1;
      for (int k = 0; k < 50 && bus.gauss_valid; k++) @(negedge clk);
      chk("sus_drain", 32'(bus.gauss_valid), 32'd0);
      chk("sus_count", bus.gauss_count, 32'd1024);
      chk("sus_deliv", 32'(n_deliv), 32'd1024);
      chk("sus_sb_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
